grf_mp: RTL

Parametrised multi-read-port general register file with write-to-read bypass and a per-register pending scoreboard, for the pipelined CPU. Sits between decode (reads, destination marking) and write-back (single write port), replacing the single-cycle two-port GRF. Decode uses the `rbusy` flags to stall while a source register awaits an in-flight producer. Register 0 is hardwired to zero.

---
 rtl/grf_pkg.sv | 14 +
 rtl/grf_mp_if.sv | 32 +++
 rtl/grf_scoreboard.sv | 60 ++++++
 rtl/grf_mp.sv | 68 ++++++
 4 files changed

// File: rtl/grf_pkg.sv
// Shared constants and packed-bus slice helpers for the multi-port register file.
// Optional trace output is enabled by defining GRF_TRACE_EN.
package grf_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned ZERO_REG   = 0;

    // LSB index of field `port` in a packed bus made of `width`-bit fields.
    function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/grf_mp_if.sv
// Decode/write-back bundle of the register file: write port, read ports, scoreboard marks.
// master = pipeline side, slave = register file side.
interface grf_mp_if
    import grf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
);
    logic                     we;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;
    logic [31:0]              wpc;
    logic [NUM_RD-1:0]        ren;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rbusy;
    logic                     stall;
    logic                     mark;
    logic [ADDR_W-1:0]        mark_addr;
    logic [ADDR_W:0]          pend_cnt;

    modport master (
        output we, waddr, wdata, wpc, ren, raddr, mark, mark_addr,
        input  rdata, rbusy, stall, pend_cnt
    );

    modport slave (
        input  we, waddr, wdata, wpc, ren, raddr, mark, mark_addr,
        output rdata, rbusy, stall, pend_cnt
    );
endinterface

// File: rtl/grf_scoreboard.sv
// Pending-producer scoreboard: one bit per register, running popcount, per-port busy flags.
// Busy is combinational; marks and clears take effect at the rising edge.
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic                     mark,
    input  logic [ADDR_W-1:0]        mark_addr,
    input  logic [NUM_RD-1:0]        ren,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD-1:0]        rbusy,
    output logic [ADDR_W:0]          pend_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pending, pend_nxt;
    logic [ADDR_W:0]  cnt_nxt;
    logic             wr_hit, mk_hit, inc, dec;

    always_comb begin
        pend_nxt = pending;
        wr_hit   = we && (waddr != ADDR_W'(ZERO_REG));
        mk_hit   = mark && (mark_addr != ADDR_W'(ZERO_REG));
        if (wr_hit) pend_nxt[waddr] = 1'b0;
        // mark applied after clear: a new producer on the same edge wins
        if (mk_hit) pend_nxt[mark_addr] = 1'b1;
        pend_nxt[0] = 1'b0;
        inc = mk_hit && !pending[mark_addr];
        dec = wr_hit && pending[waddr] && !(mk_hit && (mark_addr == waddr));
        cnt_nxt = pend_cnt;
        if (inc && !dec)      cnt_nxt = pend_cnt + (ADDR_W+1)'(1);
        else if (dec && !inc) cnt_nxt = pend_cnt - (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        rbusy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            logic [ADDR_W-1:0] ra;
            ra = raddr[slice_lo(p, ADDR_W) +: ADDR_W];
            rbusy[p] = ren[p] && pending[ra] && !((BYPASS != 0) && we && (waddr == ra));
        end
    end
endmodule

// File: rtl/grf_mp.sv
// Multi-read-port register file with write-to-read bypass and pending scoreboard; reads are 0-latency.
// Define GRF_TRACE_EN to print one line per committed write; otherwise wpc is unused.
module grf_mp
    import grf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input logic     clk,
    input logic     reset_n,
    grf_mp_if.slave io
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [0:DEPTH-1];

    // regs[0] is never written, so it holds the reset value of zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
        end else if (io.we && (io.waddr != ADDR_W'(ZERO_REG))) begin
            regs[io.waddr] <= io.wdata;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        assign ra = io.raddr[slice_lo(p, ADDR_W) +: ADDR_W];
        always_comb begin
            rd = regs[ra];
            if (ra == ADDR_W'(ZERO_REG))                           rd = '0;
            else if ((BYPASS != 0) && io.we && (io.waddr == ra))   rd = io.wdata;
        end
        assign io.rdata[slice_lo(p, DATA_W) +: DATA_W] = rd;
    end

    grf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (io.we),
        .waddr     (io.waddr),
        .mark      (io.mark),
        .mark_addr (io.mark_addr),
        .ren       (io.ren),
        .raddr     (io.raddr),
        .rbusy     (io.rbusy),
        .pend_cnt  (io.pend_cnt)
    );

    assign io.stall = |io.rbusy;

`ifdef GRF_TRACE_EN
    always @(posedge clk) begin
        if (reset_n && io.we && (io.waddr != ADDR_W'(ZERO_REG)))
            $display("@%h: $%0d <= %h", io.wpc, io.waddr, io.wdata);
    end
`else
    logic trace_unused;
    assign trace_unused = ^io.wpc;
`endif
endmodule
